coin_acceptor: RTL and testbench
================================

Name: coin_acceptor

Overview:
Front-end stage of the vending machine. It conditions the raw coin-mech sensor lines (₹5 and ₹10 chutes) by synchronising and debouncing them. It rejects invalid or unacceptable insertions and queues accepted coins in a small FIFO. Queued coins are presented to the vending FSM as one-cycle codes on coin[1:0] (2'b01 = ₹5, 2'b10 = ₹10, 2'b00 = none), separated by a guaranteed idle gap so the FSM's post-dispense state always sees coin = 00.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive identical synchronised samples required to change a debounced level (legal range 2..255)
FIFO_DEPTH, 4, accepted-coin queue entries (power of 2, 2..16)
GAP_CYCLES, 2, coin = 00 cycles forced after every emitted coin (1..15)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
sense_5  input  1  raw ₹5 chute sensor, asynchronous, high while coin passes
sense_10  input  1  raw ₹10 chute sensor, asynchronous, high while coin passes
accept_en  input  1  1 = coins may be accepted; 0 = every detected coin is rejected
coin  output  2  coin code to vending FSM, registered, one-cycle pulse per coin
reject  output  1  one-cycle pulse opening the return-chute gate
fifo_count  output  $clog2(FIFO_DEPTH)+1  current queue occupancy
fifo_full  output  1  fifo_count == FIFO_DEPTH
busy  output  1  queue non-empty or output FSM not in IDLE

Behaviour:
- Reset (asynchronous, active-high) clears all of the following: sync flops, debounce counters, debounced levels (0), FIFO pointers and count, and FSM (IDLE). Outputs during reset: coin = 00, reject = 0, fifo_count = 0, fifo_full = 0, busy = 0. Reset mid-operation discards queued coins; no coin or reject is emitted for them.
- Sync: each sensor passes through 2 flops before any use.
- Debounce, per channel: counter increments while the synchronised sample differs from the debounced level and clears when they match. When the counter reaches DEBOUNCE_CYCLES, the debounced level toggles and the counter clears. Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Event: a 0->1 transition of a debounced level is one coin event. Falling edges generate nothing.
- Classification, registered, one cycle after the event:
  - both channels' events in the same cycle -> reject pulse, nothing queued
  - single event with accept_en = 0 -> reject pulse
  - single event with fifo_full = 1, evaluated on the count before any same-cycle pop -> reject pulse
  - otherwise -> push code (01 or 10)
  - A reject and a push never occur in the same cycle.
- Output FSM states:
  - IDLE: if FIFO non-empty, pop the head and go to EMIT.
  - EMIT: coin = popped code for exactly 1 cycle, then go to GAP.
  - GAP: coin = 00 for GAP_CYCLES cycles, then go to IDLE.
  - coin is 00 in IDLE and GAP.
- Simultaneous push and pop in one cycle is legal: count unchanged, ordering FIFO.
- Latency: with an empty FIFO and FSM in IDLE, coin asserts DEBOUNCE_CYCLES + 4 clocks after the first clk edge at which the raw sensor is sampled high and then held stable.
- Minimum spacing between two nonzero coin pulses is GAP_CYCLES + 2 cycles.
- Pointers wrap modulo FIFO_DEPTH. fifo_count never exceeds FIFO_DEPTH and never underflows.
- A sensor held high through reset release is treated as a new insertion: one coin after debounce.

Optional Feature:
COIN_ACCEPTOR_TALLY_EN
- Defined:
  - Adds input tally_clr (1 bit) and output total_value (16 bits).
  - total_value accumulates the rupee value (5 or 10) of every pushed coin and saturates at 16'hFFFF. Rejected coins are not counted.
  - tally_clr = 1 synchronously clears total_value to 0; a push in the same cycle is lost from the tally.
  - Reset clears total_value to 0.
- Not defined: neither port exists and no tally logic is built.

Test Plan:
- DEBOUNCE_CYCLES = 16. sense_5 high for 40 cycles with accept_en = 1 -> exactly one coin = 01 pulse, 20 cycles after the first high sample; reject stays 0.
- sense_10 glitch of 10 cycles, then low -> coin stays 00, reject stays 0, fifo_count stays 0.
- sense_5 and sense_10 rising in the same cycle, held 40 cycles -> one reject pulse; coin stays 00.
- Five ₹10 insertions queued while coins are still being emitted, FIFO_DEPTH = 4, GAP_CYCLES = 2 -> fifo_full reaches 1, the fifth insertion yields a reject pulse, and four coin = 10 pulses are emitted exactly 4 cycles apart.
- accept_en = 0 with a ₹5 insertion -> reject pulse, nothing queued. Then accept_en = 1 and a ₹10 insertion -> coin = 10.
- Queue 3 coins, then assert reset mid-emission -> coin = 00 immediately; fifo_count = 0 and busy = 0 after release; no further pulses. With TALLY_EN, total_value reads 0 afterwards and 15 after a subsequent ₹5 + ₹10.

Source files
------------

// File: rtl/coin_acceptor_if.sv
// rtl/coin_acceptor_if.sv - coin output bus from the acceptor to the vending FSM
interface coin_acceptor_if #(
    parameter int FIFO_DEPTH = 4
);
    logic [1:0]                  coin;
    logic                        reject;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        fifo_full;
    logic                        busy;

    modport master (output coin, reject, fifo_count, fifo_full, busy);
    modport slave  (input  coin, reject, fifo_count, fifo_full, busy);
endinterface

// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - coin sensor sync/debounce, classification, coin queue and emit FSM
// Optional running rupee tally enabled by defining COIN_ACCEPTOR_TALLY_EN.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4,
    parameter int GAP_CYCLES      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sense_5,
    input  logic        sense_10,
    input  logic        accept_en,
`ifdef COIN_ACCEPTOR_TALLY_EN
    input  logic        tally_clr,
    output logic [15:0] total_value,
`endif
    coin_acceptor_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int GW = 4;

    typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

    // Bit 0 is the 5-rupee chute, bit 1 the 10-rupee chute, matching the coin code.
    logic [1:0]    raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [1:0]    deb_d;
    logic [1:0]    rise_q;
    logic [DW-1:0] cnt [2];

    logic [1:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full_now;
    logic          single;
    logic          push;
    logic          pop;

    state_t        state;
    logic [GW-1:0] gcnt;
    logic [1:0]    coin_r;
    logic          reject_r;

    assign raw = {sense_10, sense_5};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            deb    <= '0;
            deb_d  <= '0;
            rise_q <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            deb_d  <= deb;
            rise_q <= deb & ~deb_d;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt[i] <= '0;
                    deb[i] <= ~deb[i];
                end else begin
                    cnt[i] <= cnt[i] + DW'(1);
                end
            end
        end
    end

    // Fullness is judged on the occupancy before any pop in the same cycle.
    assign full_now = (count == CW'(FIFO_DEPTH));
    assign single   = rise_q[0] ^ rise_q[1];
    assign push     = single && accept_en && !full_now;
    assign pop      = (state == IDLE) && (count != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reject_r <= 1'b0;
        end else begin
            reject_r <= (&rise_q) || (single && (!accept_en || full_now));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rise_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // coin is high exactly while in EMIT; the GAP stretch keeps the consumer at 00 between coins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            gcnt   <= '0;
            coin_r <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        coin_r <= mem[rd_ptr];
                        state  <= EMIT;
                    end
                end
                EMIT: begin
                    coin_r <= 2'b00;
                    gcnt   <= '0;
                    state  <= GAP;
                end
                GAP: begin
                    if (gcnt == GW'(GAP_CYCLES - 1)) begin
                        state <= IDLE;
                    end else begin
                        gcnt <= gcnt + GW'(1);
                    end
                end
                default: begin
                    coin_r <= 2'b00;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.coin       = coin_r;
    assign bus.reject     = reject_r;
    assign bus.fifo_count = count;
    assign bus.fifo_full  = full_now;
    assign bus.busy       = (count != '0) || (state != IDLE);

`ifdef COIN_ACCEPTOR_TALLY_EN
    logic [16:0] sum;

    assign sum = {1'b0, total_value} + ((rise_q == 2'b01) ? 17'd5 : 17'd10);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total_value <= '0;
        end else if (tally_clr) begin
            total_value <= '0;
        end else if (push) begin
            total_value <= sum[16] ? 16'hFFFF : sum[15:0];
        end
    end
`endif
endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - two parameterisations of coin_acceptor checked against an event-level model
`timescale 1ns/1ps
module tb_coin_acceptor;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sense_5 = 1'b0;
    logic sense_10 = 1'b0;
    logic accept_en = 1'b1;

    always #5 clk = ~clk;

    coin_acceptor_if #(.FIFO_DEPTH(DEPTH)) bus0 ();
    coin_acceptor_if #(.FIFO_DEPTH(DEPTH)) bus1 ();

`ifdef COIN_ACCEPTOR_TALLY_EN
    logic        tally_clr = 1'b0;
    logic [15:0] total0;
    logic [15:0] total1;
`endif

    coin_acceptor #(.DEBOUNCE_CYCLES(16), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(2)) dut0 (
        .clk(clk), .reset(reset), .sense_5(sense_5), .sense_10(sense_10), .accept_en(accept_en),
`ifdef COIN_ACCEPTOR_TALLY_EN
        .tally_clr(tally_clr), .total_value(total0),
`endif
        .bus(bus0));

    coin_acceptor #(.DEBOUNCE_CYCLES(2), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(15)) dut1 (
        .clk(clk), .reset(reset), .sense_5(sense_5), .sense_10(sense_10), .accept_en(accept_en),
`ifdef COIN_ACCEPTOR_TALLY_EN
        .tally_clr(tally_clr), .total_value(total1),
`endif
        .bus(bus1));

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    // Model: debounce as "D consecutive disagreeing samples", coins as a queue of codes,
    // emitter as "earliest next pop time".
    logic [1:0] m_s1, m_s2;
    int         lvl [2][2];
    int         run [2][2];
    logic [1:0] e1 [2];
    logic [1:0] e2 [2];
    logic [1:0] mq [2][4096];
    int         mh [2];
    int         mt [2];
    int         last_pop [2];
    logic [1:0] exp_coin [2];
    logic       exp_rej [2];

    int         coins_seen [2];
    int         rej_seen [2];
    int         first_coin [2];
    int         last_coin [2];
    int         min_space [2];
    logic       saw_full [2];
    logic [1:0] last_code [2];

    function automatic int deb_of(int i);
        return (i == 0) ? 16 : 2;
    endfunction

    function automatic int gap_of(int i);
        return (i == 0) ? 2 : 15;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic reset_model();
        m_s1 = '0;
        m_s2 = '0;
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 2; c++) begin
                lvl[i][c] = 0;
                run[i][c] = 0;
            end
            e1[i] = '0;
            e2[i] = '0;
            mh[i] = 0;
            mt[i] = 0;
            last_pop[i] = -1000;
            exp_coin[i] = '0;
            exp_rej[i] = 1'b0;
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 2; i++) begin
            coins_seen[i] = 0;
            rej_seen[i] = 0;
            first_coin[i] = -1;
            last_coin[i] = -100000;
            min_space[i] = 100000;
            saw_full[i] = 1'b0;
            last_code[i] = '0;
        end
    endtask

    task automatic model_edge(input logic [1:0] raw, input logic acc, input logic rst);
        logic [1:0] s;
        int         cnt_before;
        if (rst) begin
            reset_model();
            return;
        end
        s = m_s2;
        m_s2 = m_s1;
        m_s1 = raw;
        for (int i = 0; i < 2; i++) begin
            cnt_before = mt[i] - mh[i];
            exp_coin[i] = '0;
            exp_rej[i] = 1'b0;
            if (cnt_before > 0 && cyc >= last_pop[i] + gap_of(i) + 2) begin
                exp_coin[i] = mq[i][mh[i]];
                mh[i]++;
                last_pop[i] = cyc;
            end
            if (e2[i] == 2'b11) begin
                exp_rej[i] = 1'b1;
            end else if (e2[i] != 2'b00) begin
                if (!acc || cnt_before == DEPTH) begin
                    exp_rej[i] = 1'b1;
                end else begin
                    mq[i][mt[i]] = e2[i];
                    mt[i]++;
                end
            end
            e2[i] = e1[i];
            e1[i] = '0;
            for (int c = 0; c < 2; c++) begin
                if (int'(s[c]) != lvl[i][c]) begin
                    run[i][c]++;
                    if (run[i][c] == deb_of(i)) begin
                        lvl[i][c] = 1 - lvl[i][c];
                        run[i][c] = 0;
                        if (lvl[i][c] == 1) e1[i][c] = 1'b1;
                    end
                end else begin
                    run[i][c] = 0;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [7:0] act;
        logic [7:0] exp;
        int         cnt;
        for (int i = 0; i < 2; i++) begin
            act = (i == 0) ? {bus0.coin, bus0.reject, bus0.fifo_count, bus0.fifo_full, bus0.busy}
                           : {bus1.coin, bus1.reject, bus1.fifo_count, bus1.fifo_full, bus1.busy};
            cnt = mt[i] - mh[i];
            exp = {exp_coin[i], exp_rej[i], 3'(cnt), (cnt == DEPTH),
                   (cnt > 0) || (cyc <= last_pop[i] + gap_of(i))};
            check((i == 0) ? "dut0 outputs" : "dut1 outputs", 32'(act), 32'(exp));
            if (act[7:6] != 2'b00) begin
                coins_seen[i]++;
                if (first_coin[i] < 0) first_coin[i] = cyc;
                if (cyc - last_coin[i] < min_space[i]) min_space[i] = cyc - last_coin[i];
                last_coin[i] = cyc;
                last_code[i] = act[7:6];
            end
            if (act[5]) rej_seen[i]++;
            if (act[1]) saw_full[i] = 1'b1;
        end
    endtask

    task automatic step();
        logic [1:0] raw_now;
        logic       acc_now;
        logic       rst_now;
        raw_now = {sense_10, sense_5};
        acc_now = accept_en;
        rst_now = reset;
        @(posedge clk);
        cyc++;
        model_edge(raw_now, acc_now, rst_now);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic pulse(input logic s5, input logic s10, input int hi, input int lo);
        sense_5 = s5;
        sense_10 = s10;
        idle(hi);
        sense_5 = 1'b0;
        sense_10 = 1'b0;
        idle(lo);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        #1;
        reset_model();
        check("reset coin dut0", 32'(bus0.coin), 32'd0);
        check("reset coin dut1", 32'(bus1.coin), 32'd0);
        idle(n);
        reset = 1'b0;
    endtask

    initial begin
        int start;
        reset_model();
        clear_stats();
        do_reset(3);
        check("reset count dut0", 32'(bus0.fifo_count), 32'd0);
        check("reset busy dut0", 32'(bus0.busy), 32'd0);
        check("reset full dut1", 32'(bus1.fifo_full), 32'd0);

        // Single 5-rupee coin: latency D+4 after the first high sample.
        clear_stats();
        start = cyc + 1;
        pulse(1'b1, 1'b0, 40, 40);
        check("latency dut0", 32'(first_coin[0] - start), 32'd20);
        check("latency dut1", 32'(first_coin[1] - start), 32'd6);
        check("single coins dut0", 32'(coins_seen[0]), 32'd1);
        check("single code dut0", 32'(last_code[0]), 32'd1);
        check("single rejects dut0", 32'(rej_seen[0]), 32'd0);

        // Short glitch on the 10-rupee line.
        clear_stats();
        pulse(1'b0, 1'b1, 10, 40);
        check("glitch coins dut0", 32'(coins_seen[0]), 32'd0);
        check("glitch rejects dut0", 32'(rej_seen[0]), 32'd0);

        // Both chutes at once.
        clear_stats();
        pulse(1'b1, 1'b1, 40, 40);
        check("both rejects dut0", 32'(rej_seen[0]), 32'd1);
        check("both coins dut0", 32'(coins_seen[0]), 32'd0);
        check("both rejects dut1", 32'(rej_seen[1]), 32'd1);

        // Acceptance disabled, then re-enabled.
        clear_stats();
        accept_en = 1'b0;
        pulse(1'b1, 1'b0, 40, 40);
        check("disabled rejects dut0", 32'(rej_seen[0]), 32'd1);
        check("disabled coins dut0", 32'(coins_seen[0]), 32'd0);
        clear_stats();
        accept_en = 1'b1;
        pulse(1'b0, 1'b1, 40, 40);
        check("enabled coins dut0", 32'(coins_seen[0]), 32'd1);
        check("enabled code dut0", 32'(last_code[0]), 32'd2);

        // Burst faster than the slow-gap instance drains: fills, rejects overflow.
        clear_stats();
        for (int k = 0; k < 12; k++) pulse(1'b0, 1'b1, 3, 3);
        idle(100);
        check("burst accounted dut1", 32'(coins_seen[1] + rej_seen[1]), 32'd12);
        check("burst full dut1", 32'(saw_full[1]), 32'd1);
        check("burst overflow dut1", 32'(rej_seen[1] != 0), 32'd1);
        check("burst spacing dut1", 32'(min_space[1]), 32'd17);
        check("burst coins dut0", 32'(coins_seen[0]), 32'd0);

        // Reset while coins are still queued.
        clear_stats();
        for (int k = 0; k < 3; k++) pulse(1'b0, 1'b1, 3, 3);
        for (int k = 0; k < 60 && coins_seen[1] == 0; k++) step();
        check("emitting before reset", 32'(coins_seen[1] != 0), 32'd1);
        check("queued before reset", 32'(bus1.fifo_count != 0), 32'd1);
        do_reset(3);
        check("post reset count dut1", 32'(bus1.fifo_count), 32'd0);
        check("post reset busy dut1", 32'(bus1.busy), 32'd0);
        clear_stats();
        idle(60);
        check("post reset coins dut1", 32'(coins_seen[1]), 32'd0);
        check("post reset rejects dut1", 32'(rej_seen[1]), 32'd0);

        // Random sensor activity.
        for (int seg = 0; seg < 80; seg++) begin
            if ($urandom_range(0, 24) == 0) begin
                do_reset(2);
            end else begin
                sense_5 = 1'($urandom_range(0, 1));
                sense_10 = 1'($urandom_range(0, 1));
                accept_en = ($urandom_range(0, 3) != 0);
                idle(int'($urandom_range(1, 30)));
            end
        end
        sense_5 = 1'b0;
        sense_10 = 1'b0;
        idle(120);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
